// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmitter and the receiver.
//   - FSM state encoding (IDLE/START/DATA/PARITY/STOP) shared with the receive path
//   - Default frame constants DEF_DATA_BITS / DEF_OVERSAMPLE
//   - BAUD_COUNT: clocks between 16x oversample ticks at 100 MHz / 9600 baud
package uart_pkg;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  typedef enum logic [2:0] {
    StIdle   = IDLE,
    StStart  = START,
    StData   = DATA,
    StParity = PARITY,
    StStop   = STOP
  } uart_state_e;

  localparam int unsigned DEF_DATA_BITS  = 8;
  localparam int unsigned DEF_OVERSAMPLE = 16;

  localparam int unsigned SYS_CLK_HZ = 100_000_000;
  localparam int unsigned BAUD_RATE  = 9600;

  function automatic int unsigned baud_count(int unsigned clk_hz, int unsigned baud,
                                             int unsigned oversample);
    return clk_hz / (baud * oversample);
  endfunction

  // 100_000_000 / (9600 * 16) = 651 (truncated)
  localparam int unsigned BAUD_COUNT = baud_count(SYS_CLK_HZ, BAUD_RATE, DEF_OVERSAMPLE);

endpackage

// File: rtl/uart_tx_if.sv
// Byte-level handshake between the UART transmitter and its user.
//   start   : request to send tx_data (honoured only when idle)
//   tx_data : byte to send, sampled on the accept cycle
//   tx      : serial line, idles high
//   busy    : frame in progress
//   done    : one-clk pulse when the last stop bit completes
// master = user side, slave = transmitter side.
interface uart_tx_if import uart_pkg::*; #(
  parameter int unsigned DATA_BITS = DEF_DATA_BITS
) ();

  logic                 start;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx;
  logic                 busy;
  logic                 done;

  modport master (
    output start,
    output tx_data,
    input  tx,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  tx_data,
    output tx,
    output busy,
    output done
  );

endinterface

// File: rtl/uart_tx.sv
// UART transmitter: serialises one byte per accepted start, LSB first, 8N1 by default.
// Bit timing comes from the shared 16x oversample tick (b_tick).
// Ports:
//   clk    : system clock (100 MHz)
//   reset  : synchronous, active-low
//   b_tick : one-clk oversample tick from the baud tick generator
//   bus    : uart_tx_if.slave (start, tx_data in; tx, busy, done out, all registered)
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit (8E1).
module uart_tx import uart_pkg::*; #(
  parameter int unsigned DATA_BITS  = DEF_DATA_BITS,
  parameter int unsigned OVERSAMPLE = DEF_OVERSAMPLE,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       b_tick,
  uart_tx_if.slave   bus
);

  localparam int unsigned TickW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int unsigned BitW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [TickW-1:0] TickLast = TickW'(OVERSAMPLE - 1);
  localparam logic [BitW-1:0]  BitLast  = BitW'(DATA_BITS - 1);
  localparam logic             StopLast = (STOP_BITS > 1);

  uart_state_e          state_q, state_d;
  logic [TickW-1:0]     tick_cnt_q, tick_cnt_d;
  logic [BitW-1:0]      bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  logic bit_end;

  // A bit ends on the OVERSAMPLE-th tick counted from entry into that bit.
  assign bit_end = b_tick && (tick_cnt_q == TickLast);

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    shift_d    = shift_q;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif

    // Ticks only count inside a frame; the terminal tick is handled per state.
    if ((state_q != StIdle) && b_tick && !bit_end) begin
      tick_cnt_d = tick_cnt_q + TickW'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d    = StStart;
          shift_d    = bus.tx_data;
          tick_cnt_d = '0;
          bit_cnt_d  = '0;
          stop_cnt_d = 1'b0;
`ifdef UART_TX_PARITY_EN
          parity_d   = ^bus.tx_data;
`endif
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d    = StData;
          tick_cnt_d = '0;
          bit_cnt_d  = '0;
        end
      end
      StData: begin
        if (bit_end) begin
          tick_cnt_d = '0;
          shift_d    = shift_q >> 1;
          if (bit_cnt_q == BitLast) begin
`ifdef UART_TX_PARITY_EN
            state_d    = StParity;
`else
            state_d    = StStop;
`endif
            stop_cnt_d = 1'b0;
          end else begin
            bit_cnt_d = bit_cnt_q + BitW'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (bit_end) begin
          state_d    = StStop;
          tick_cnt_d = '0;
          stop_cnt_d = 1'b0;
        end
      end
`endif
      StStop: begin
        if (bit_end) begin
          tick_cnt_d = '0;
          if (stop_cnt_q == StopLast) begin
            state_d = StIdle;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Registered outputs are derived from the next state so they change with it.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = 1'b1;
    unique case (state_d)
      StIdle: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
      end
      StStart: tx_d = 1'b0;
      StData:  tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      StParity: tx_d = parity_q;
`endif
      StStop:  tx_d = 1'b1;
      default: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
      end
    endcase
    done_d = (state_q == StStop) && (state_d == StIdle);
  end

  assign bus.tx   = tx_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- 8N1 UART transmitter; transmit counterpart of the UART receive path.
- Consumes the shared 16x-oversample baud tick (100 MHz / (9600*16), one-clk pulse every 651 clks).
- Accepts one byte per start pulse and serialises it LSB-first on tx.
- Sits between the control logic or loopback path and the board TX pin.

Parameters:
DATA_BITS, 8, data bits per frame
OVERSAMPLE, 16, b_tick pulses per bit period
STOP_BITS, 1, stop bits per frame (1 or 2)

Ports:
clk  input  1  system clock, 100 MHz
reset  input  1  synchronous, active-low reset: sampled on posedge clk, asserted when 0
b_tick  input  1  one-clk oversample tick from the baud tick generator
start  input  1  request: send tx_data; honoured only in IDLE
tx_data  input  DATA_BITS  byte to send; sampled on the accept cycle only
tx  output  1  serial line; idles high
busy  output  1  high from the cycle after accept through the last stop-bit cycle
done  output  1  one-clk pulse when the final stop bit completes

Behaviour:
- Reset (reset==0 at posedge): state=IDLE, tx=1, busy=0, done=0, tick_cnt=0, bit_cnt=0, shift reg=0. Reset mid-frame abandons the frame. tx returns high on that edge, with no partial stop bit.
- All outputs are registered. start, tx_data and b_tick are sampled at posedge clk.
- FSM states: IDLE, START, DATA, STOP (plus PARITY under the optional feature).
- IDLE:
  - tx=1, busy=0.
  - If start==1: latch tx_data into the shift register, go to START.
  - From the next cycle: tx=0, busy=1.
- Bit timing:
  - tick_cnt clears on entry to every bit.
  - It increments on each b_tick.
  - The bit ends on the clk cycle where b_tick==1 and tick_cnt==OVERSAMPLE-1.
  - Bit period is therefore exactly OVERSAMPLE ticks, counted from entry. The start bit is at most one tick-period minus one clk longer than the ticked portion, because accept is not tick-aligned.
- START: after one bit period, go to DATA with bit_cnt=0. tx = shift[0].
- DATA:
  - At each bit end, shift right and bit_cnt++.
  - After bit_cnt reaches DATA_BITS-1 and that bit ends, go to STOP. tx=1.
- STOP:
  - Lasts STOP_BITS bit periods.
  - On the final end: go to IDLE, done=1 for exactly that one cycle, busy=0 in that same cycle.
- start while busy==1 (including the done cycle): ignored, not queued. tx_data changes while busy have no effect.
- Back-to-back: start asserted in the cycle after done is accepted. Minimum inter-frame gap is one clk of idle-high.
- b_tick in IDLE is ignored. A b_tick coinciding with accept is not counted.
- Counter widths: tick_cnt is $clog2(OVERSAMPLE) bits; bit_cnt is $clog2(DATA_BITS) bits. Neither wraps past its terminal value.
- Frame length at defaults: 10 bit periods = 160 ticks = 104,160 clks (±1 tick-period on the start bit).

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - It transmits an even-parity bit, equal to the XOR of the latched byte.
  - It lasts one bit period. Frame becomes 8E1, 11 bit periods.
- Undefined: no PARITY state, no parity logic, 8N1.

Decomposition:
- Shared package uart_pkg holds:
  - FSM state encoding (localparams IDLE=0, START=1, DATA=2, PARITY=3, STOP=4), shared with the receiver.
  - DEF_DATA_BITS=8 and DEF_OVERSAMPLE=16 constants.
  - The BAUD_COUNT derivation (100_000_000/(9600*16)).
- No sub-module. The tick source is the existing baud tick generator, instantiated by the parent. uart_tx is a single FSM plus datapath.

Test Plan:
- Bench drives b_tick every 4 clks (bit period = 64 clks). start=1 with tx_data=8'hA5:
  - tx sequence 0, then 1,0,1,0,0,1,0,1, then 1, with data bits LSB-first and each data/stop bit 64 clks.
  - busy high throughout. done pulses once for 1 clk, aligned with busy falling.
- Send 8'h00, then 8'hFF, with start held high continuously:
  - Second frame begins exactly 1 clk after done.
  - No glitch on tx. Start bit low for 64 clks.
- start pulsed mid-DATA with tx_data=8'h3C while sending 8'h55: only the 8'h55 frame appears on tx, and done pulses once.
- reset=0 for one clk during DATA bit 3:
  - Next edge: tx=1, busy=0, done=0.
  - No further transitions until a new start. A following 8'h81 frame is bit-exact.
- Real generator (651-clk tick), tx_data=8'h41: frame length within 104,160 ± 651 clks. Loopback into the UART receiver yields 8'h41.
- With UART_TX_PARITY_EN: tx_data=8'h07 gives parity bit 1; tx_data=8'h03 gives 0. Frame is 11 bit periods.
